// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of (PC, instr) pairs.
// Optional same-cycle pass-through when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_pop;
  logic w_push;
  logic w_deq;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  assign in_ready = !w_full && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass  = w_empty && in_valid && !flush;
  assign out_valid = !w_empty || w_bypass;
  assign out_pc    = !w_empty ? r_pc[r_rptr] :
                     (w_bypass ? in_pc : 32'h0);
  assign out_instr = !w_empty ? r_instr[r_rptr] :
                     (w_bypass ? in_instr : 32'h0);
`else
  assign w_bypass  = 1'b0;
  assign out_valid = !w_empty;
  assign out_pc    = !w_empty ? r_pc[r_rptr] : 32'h0;
  assign out_instr = !w_empty ? r_instr[r_rptr] : 32'h0;
`endif

  // A bypassed word consumed this cycle never touches storage.
  assign w_pop  = out_valid && out_ready;
  assign w_deq  = w_pop && !w_empty;
  assign w_push = in_valid && in_ready && !(w_bypass && out_ready);

  assign count    = r_count;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_pc[r_wptr]    <= in_pc;
      r_instr[r_wptr] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready && !flush)
        r_overflow <= 1'b1;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + PTR_W'(1);
        if (w_deq)
          r_rptr <= r_rptr + PTR_W'(1);
        unique case ({w_push, w_deq})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
